mem_access_stage: RTL

- Parametrised MEM stage for the pipelined MIPS datapath. Sits between EX/MEM and MEM/WB.
- Owns a byte-lane data memory with configurable depth and wait-state latency.
- Supports byte/half/word loads (sign- or zero-extended) and stores, detects misaligned accesses, and stalls upstream while a multi-cycle access is in flight.
- Output is a registered result: load data, or the ALU result passed through for non-memory instructions.

---
 rtl/mem_stage_pkg.sv | 87 ++++++++
 rtl/byte_lane_ram.sv | 24 ++
 rtl/mem_access_stage.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the MEM stage.
// Size codes, FSM states, request bundle, lane logic.
package mem_stage_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic m;
        m = 1'b0;
        case (size)
            SIZE_BYTE: m = 1'b0;
            SIZE_HALF: m = off[0];
            default:   m = (off != 2'b00);
        endcase
        return m;
    endfunction

    function automatic logic [3:0] byte_en(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic [3:0] be;
        be = 4'b1111;
        case (size)
            SIZE_BYTE: be = 4'b0001 << off;
            SIZE_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the store data so every lane sees its own slice;
    // the byte enables pick which lanes actually change.
    function automatic logic [31:0] store_lanes(
        input logic [1:0]  size,
        input logic [31:0] wd
    );
        logic [31:0] d;
        d = wd;
        case (size)
            SIZE_BYTE: d = {4{wd[7:0]}};
            SIZE_HALF: d = {2{wd[15:0]}};
            default:   d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extract(
        input logic [31:0] word,
        input logic [1:0]  off,
        input logic [1:0]  size,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        r = word;
        case (size)
            SIZE_BYTE: r = uns ? {24'h0, b} : {{24{b[7]}}, b};
            SIZE_HALF: r = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default:   r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// Word-organised data memory with per-byte write enables.
// Synchronous write, combinational read, no reset.
module byte_lane_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [0:(2**ADDR_W)-1];

    // Write only the enabled byte lanes of the addressed word.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: byte/half/word loads and stores
// with wait-state latency, misalign rejection and stall.
import mem_stage_pkg::*;

module mem_access_stage #(
    parameter int ADDR_W      = 10,
    parameter int MEM_LATENCY = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Valid_in,
    input  logic        MemRead_in,
    input  logic        MemWrite_in,
    input  logic [1:0]  Size_in,
    input  logic        Unsigned_in,
    input  logic [31:0] ALUResult_in,
    input  logic [31:0] WriteData_in,
    output logic        Stall_out,
    output logic        Valid_out,
    output logic [31:0] Result_out,
    output logic        Misalign_out
);

    localparam int LAT_M2 = (MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0;
    localparam logic [2:0] CNT_INIT = LAT_M2[2:0];

    state_t      state;
    state_t      state_nx;
    logic [2:0]  cnt;
    logic [2:0]  cnt_nx;
    mem_req_t    req_in;
    mem_req_t    req_q;
    mem_req_t    sel;
    logic        latch;
    logic        commit;
    logic        fire;
    logic        mis_nx;
    logic [31:0] res_nx;
    logic        is_mem;
    logic        is_mis;
    logic        we;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic [31:0] mem_res;

    assign req_in = '{
        rd:    MemRead_in,
        wr:    MemWrite_in,
        size:  Size_in,
        uns:   Unsigned_in,
        addr:  ALUResult_in,
        wdata: WriteData_in
    };

    // In WAIT the latched request drives the memory, never the inputs.
    assign sel    = (state == ST_WAIT) ? req_q : req_in;
    assign is_mem = sel.rd | sel.wr;
    assign is_mis = misaligned(sel.size, sel.addr[1:0]);

    assign we = commit & sel.wr & ~Reset;
    assign be = byte_en(sel.size, sel.addr[1:0]) & {4{we}};

    byte_lane_ram #(
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk  (Clk),
        .be   (be),
        .addr (sel.addr[ADDR_W+1:2]),
        .wdata(store_lanes(sel.size, sel.wdata)),
        .rdata(rdata)
    );

    // Stores (including read+write) report the address.
    assign mem_res = sel.wr ? sel.addr
                   : load_extract(rdata, sel.addr[1:0],
                                  sel.size, sel.uns);

    // Next state, stall and next-result selection.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        Stall_out = 1'b0;
        latch     = 1'b0;
        commit    = 1'b0;
        fire      = 1'b0;
        mis_nx    = 1'b0;
        res_nx    = 32'h0;
        case (state)
            ST_IDLE: begin
                if (Valid_in) begin
                    if (!is_mem) begin
                        fire   = 1'b1;
                        res_nx = sel.addr;
                    end else if (is_mis) begin
                        fire   = 1'b1;
                        mis_nx = 1'b1;
                    end else if (MEM_LATENCY == 1) begin
                        commit = 1'b1;
                        fire   = 1'b1;
                        res_nx = mem_res;
                    end else begin
                        latch     = 1'b1;
                        Stall_out = 1'b1;
                        cnt_nx    = CNT_INIT;
                        state_nx  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                Stall_out = (cnt != 3'd0);
                if (cnt == 3'd0) begin
                    commit   = 1'b1;
                    fire     = 1'b1;
                    res_nx   = mem_res;
                    state_nx = ST_IDLE;
                end else begin
                    cnt_nx = cnt - 3'd1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // FSM, counter and registered result.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= ST_IDLE;
            cnt          <= 3'd0;
            Valid_out    <= 1'b0;
            Misalign_out <= 1'b0;
            Result_out   <= 32'h0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            Valid_out    <= fire;
            Misalign_out <= mis_nx;
            if (fire) Result_out <= res_nx;
        end
    end

    // Capture the request held by upstream on acceptance.
    always_ff @(posedge Clk) begin
        if (latch) req_q <= req_in;
    end

endmodule
